preamble_sfd_detector: RTL and testbench

PREAMBLE_SFD_DETECTOR -- requirements
Module: preamble_sfd_detector

---
 rtl/eth_rx_pkg.sv | 18 +
 rtl/preamble_sfd_detector.sv | 121 ++++++++++++
 tb/tb_preamble_sfd_detector.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive front end: detector states and
// the preamble/SFD byte values.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int unsigned     CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/preamble_sfd_detector.sv
// GMII-style preamble/SFD detector: validates the 0x55 run and the SFD, then
// forwards payload bytes with one cycle of latency and frames them with pulses.
module preamble_sfd_detector
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_PREAMBLE = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_dv,
  input  logic [7:0] rx_data,
  output logic       frame_active,
  output logic       frame_start,
  output logic       frame_end,
  output logic       preamble_err,
  output logic [7:0] data_out,
  output logic       data_valid
);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, start_q, end_q, err_q, dv_q;
  logic             start_d, end_d, err_d, dv_d;
  logic [7:0]       data_q, data_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    end_d   = 1'b0;
    err_d   = 1'b0;
    dv_d    = 1'b0;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (rx_dv) begin
          if (rx_data == PREAMBLE_BYTE) begin
            state_d = PREAMBLE;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = DROP;
            err_d   = 1'b1;
          end
        end
      end

      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else if (rx_data == PREAMBLE_BYTE) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end else if (rx_data == SFD_BYTE && 32'(cnt_q) >= MIN_PREAMBLE) begin
          state_d = DATA;
          start_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = DROP;
          err_d   = 1'b1;
          cnt_d   = '0;
        end
      end

      DATA: begin
        if (!rx_dv) begin
          state_d = IDLE;
          end_d   = 1'b1;
        end else begin
          dv_d   = 1'b1;
          data_d = rx_data;
        end
      end

      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // frame_active is its own flop (not a decode of state_q) so every output
  // comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload register is reset too, so data_out reads 0 after
      // reset rather than a stale byte from an abandoned frame.
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      dv_q     <= 1'b0;
      data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from
      // the values sampled on this edge.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d == DATA);
      start_q  <= start_d;
      end_q    <= end_d;
      err_q    <= err_d;
      dv_q     <= dv_d;
      data_q   <= data_d;
    end
  end

  assign frame_active = active_q;
  assign frame_start  = start_q;
  assign frame_end    = end_q;
  assign preamble_err = err_q;
  assign data_valid   = dv_q;
  assign data_out     = data_q;

endmodule

// File: tb/tb_preamble_sfd_detector.sv
// Self-checking bench for preamble_sfd_detector: directed bursts plus random
// bursts, each scored against a burst-level model of the detector's rules.
module tb_preamble_sfd_detector;
  import eth_rx_pkg::*;

  localparam int MIN = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       frame_active, frame_start, frame_end, preamble_err, data_valid;
  logic [7:0] data_out;

  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] burst[$];
  int         act_cycles;

  preamble_sfd_detector #(.MIN_PREAMBLE(MIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_dv        (rx_dv),
    .rx_data      (rx_data),
    .frame_active (frame_active),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .preamble_err (preamble_err),
    .data_out     (data_out),
    .data_valid   (data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_act, input bit e_st,
                         input bit e_end, input bit e_err, input bit e_dv);
    chk({tag, ".frame_active"}, {7'b0, frame_active}, {7'b0, e_act});
    chk({tag, ".frame_start"},  {7'b0, frame_start},  {7'b0, e_st});
    chk({tag, ".frame_end"},    {7'b0, frame_end},    {7'b0, e_end});
    chk({tag, ".preamble_err"}, {7'b0, preamble_err}, {7'b0, e_err});
    chk({tag, ".data_valid"},   {7'b0, data_valid},   {7'b0, e_dv});
    chk({tag, ".data_out"},     data_out,             last_data);
  endtask

  task automatic idle_step();
    rx_dv   = 1'b0;
    rx_data = 8'($urandom);
    @(negedge clk);
    chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Classify the whole burst up front (leading 0x55 run, what follows it),
  // then check every cycle of the burst and of the trailing rx_dv=0 cycle.
  task automatic run_burst(input string tag);
    int len;
    int n;
    int err_at;
    int sat;
    bit accept;
    bit e_dv;
    len = burst.size();
    n   = 0;
    while (n < len && burst[n] == PREAMBLE_BYTE) n++;
    sat    = (n > 15) ? 15 : n;
    accept = (n > 0) && (n < len) && (burst[n] == SFD_BYTE) && (sat >= MIN);
    err_at = (len > 0 && !accept) ? n : -1;
    act_cycles = 0;
    for (int k = 0; k <= len; k++) begin
      if (k < len) begin
        rx_dv   = 1'b1;
        rx_data = burst[k];
      end else begin
        rx_dv   = 1'b0;
        rx_data = 8'($urandom);
      end
      @(negedge clk);
      e_dv = accept && (k > n) && (k < len);
      if (e_dv) last_data = burst[k];
      if (frame_active) act_cycles++;
      chk_all(tag, accept && k >= n && k < len, accept && k == n,
              accept && k == len, k == err_at, e_dv);
      if (k < n) chk({tag, ".cnt"}, {4'b0, dut.cnt_q}, 8'((k + 1 > 15) ? 15 : k + 1));
    end
  endtask

  task automatic push_pre(input int n);
    for (int i = 0; i < n; i++) burst.push_back(PREAMBLE_BYTE);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_dv   = 1'b1;
    rx_data = 8'h55;
    repeat (2) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.cnt", {4'b0, dut.cnt_q}, 8'h00);
    rx_dv = 1'b0;
    rst_n = 1'b1;
    idle_step();

    // Nominal frame with three payload bytes
    burst = {}; push_pre(7); burst.push_back(SFD_BYTE);
    burst.push_back(8'h11); burst.push_back(8'h22); burst.push_back(8'h33);
    run_burst("basic");
    chk("basic.active_cycles", 8'(act_cycles), 8'd4);

    // Short preamble, then a valid frame after rx_dv drops
    burst = {}; push_pre(5); burst.push_back(SFD_BYTE);
    burst.push_back(8'h10); burst.push_back(8'h20);
    run_burst("short");
    chk("short.active_cycles", 8'(act_cycles), 8'd0);
    burst = {}; push_pre(8); burst.push_back(SFD_BYTE); burst.push_back(8'hA5);
    run_burst("after_short");

    // Bad byte inside the preamble; a later SFD in the same burst is ignored
    burst = {8'h55, 8'h55, 8'hA0, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
             8'h55, 8'h55, 8'h55, 8'hD5, 8'h44};
    run_burst("badbyte");
    chk("badbyte.active_cycles", 8'(act_cycles), 8'd0);

    // Counter reaching and holding at 15
    burst = {}; push_pre(15); burst.push_back(SFD_BYTE); burst.push_back(8'h7E);
    run_burst("sat15");
    chk("sat15.data_out", data_out, 8'h7E);
    burst = {}; push_pre(20); burst.push_back(SFD_BYTE); burst.push_back(8'h3C);
    run_burst("sat20");

    // Reset pulse during the second payload byte
    rx_dv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rx_data = PREAMBLE_BYTE;
      @(negedge clk);
      chk_all("rst.pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rx_data = SFD_BYTE;
    @(negedge clk);
    chk_all("rst.sfd", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rx_data = 8'h11;
    @(negedge clk);
    last_data = 8'h11;
    chk_all("rst.p1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rx_data = 8'h22;
    @(posedge clk);
    #1;
    last_data = 8'h22;
    chk_all("rst.p2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    last_data = 8'h00;
    chk_all("rst.clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.cnt", {4'b0, dut.cnt_q}, 8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    rx_data = 8'h33;
    @(negedge clk);
    chk_all("rst.drop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_step();
    burst = {}; push_pre(7); burst.push_back(SFD_BYTE);
    burst.push_back(8'h5A); burst.push_back(8'hC3);
    run_burst("rst.next");

    // Zero-payload frame, then a back-to-back frame after a single idle cycle
    burst = {}; push_pre(7); burst.push_back(SFD_BYTE);
    run_burst("zero");
    burst = {}; push_pre(7); burst.push_back(SFD_BYTE); burst.push_back(8'h01);
    run_burst("b2b");
    chk("b2b.data_out", data_out, 8'h01);

    // Random bursts
    for (int it = 0; it < 60; it++) begin
      int kind;
      kind  = $urandom_range(0, 3);
      burst = {};
      case (kind)
        0: begin
          push_pre($urandom_range(0, 18));
          burst.push_back(SFD_BYTE);
          for (int j = $urandom_range(0, 6); j > 0; j--) burst.push_back(8'($urandom));
        end
        1: begin
          push_pre($urandom_range(0, 10));
          burst.push_back(8'($urandom));
          for (int j = $urandom_range(0, 4); j > 0; j--) burst.push_back(8'($urandom));
        end
        2: push_pre($urandom_range(1, 10));
        default: for (int j = $urandom_range(1, 5); j > 0; j--) burst.push_back(8'($urandom));
      endcase
      run_burst("rand");
      for (int j = $urandom_range(0, 2); j > 0; j--) idle_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
